// File: rtl/memref_arb2.sv
// memref_arb2: round-robin arbiter sharing one single-port memref between two requesters.
// Optional 16-bit saturating contention counter enabled by MEMREF_ARB_PERF_EN.
module memref_arb2 #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_en,
  input  logic              r0_wr_en,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [WIDTH-1:0]  r0_wr_data,
  output logic              r0_gnt,
  output logic              r0_rd_valid,
  output logic [WIDTH-1:0]  r0_rd_data,
  input  logic              r1_en,
  input  logic              r1_wr_en,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [WIDTH-1:0]  r1_wr_data,
  output logic              r1_gnt,
  output logic              r1_rd_valid,
  output logic [WIDTH-1:0]  r1_rd_data,
  output logic              mem_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wr_data,
  input  logic [WIDTH-1:0]  mem_rd_data
`ifdef MEMREF_ARB_PERF_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);
  logic prio_q, prio_d;
  logic pend_v_q, pend_v_d;
  logic pend_id_q, pend_id_d;
  always_comb begin
    r0_gnt      = !rst && r0_en && (!r1_en || !prio_q);
    r1_gnt      = !rst && r1_en && (!r0_en || prio_q);
    mem_en      = r0_gnt || r1_gnt;
    mem_wr_en   = r0_gnt ? r0_wr_en : r1_gnt ? r1_wr_en : 1'b0;
    mem_addr    = r0_gnt ? r0_addr : r1_gnt ? r1_addr : '0;
    mem_wr_data = r0_gnt ? r0_wr_data : r1_gnt ? r1_wr_data : '0;
    prio_d      = r0_gnt ? 1'b1 : r1_gnt ? 1'b0 : prio_q;
    pend_v_d    = (r0_gnt && !r0_wr_en) || (r1_gnt && !r1_wr_en);
    pend_id_d   = r1_gnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q    <= 1'b0;
      pend_v_q  <= 1'b0;
      pend_id_q <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      pend_v_q  <= pend_v_d;
      pend_id_q <= pend_id_d;
    end
  end
  // A read tag left over from before reset must not surface while rst is high.
  always_comb begin
    r0_rd_valid = pend_v_q && !pend_id_q && !rst;
    r1_rd_valid = pend_v_q && pend_id_q && !rst;
    r0_rd_data  = r0_rd_valid ? mem_rd_data : '0;
    r1_rd_data  = r1_rd_valid ? mem_rd_data : '0;
  end
`ifdef MEMREF_ARB_PERF_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = (r0_en && r1_en && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign conflict_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_memref_arb2.sv
// tb_memref_arb2: randomized + directed scoreboard bench for memref_arb2 against a memref model.
module tb_memref_arb2;
  logic clk = 0, rst = 1;
  logic r0_en = 0, r0_wr_en = 0, r1_en = 0, r1_wr_en = 0;
  logic [5:0] r0_addr = 0, r1_addr = 0;
  logic [31:0] r0_wr_data = 0, r1_wr_data = 0;
  logic r0_gnt, r1_gnt, r0_rd_valid, r1_rd_valid;
  logic [31:0] r0_rd_data, r1_rd_data;
  logic mem_en, mem_wr_en;
  logic [5:0] mem_addr;
  logic [31:0] mem_wr_data, mem_rd_q;
`ifdef MEMREF_ARB_PERF_EN
  logic [15:0] conflict_cnt;
  int exp_cnt = 0;
`endif

  memref_arb2 #(.WIDTH(32), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst),
    .r0_en(r0_en), .r0_wr_en(r0_wr_en), .r0_addr(r0_addr), .r0_wr_data(r0_wr_data),
    .r0_gnt(r0_gnt), .r0_rd_valid(r0_rd_valid), .r0_rd_data(r0_rd_data),
    .r1_en(r1_en), .r1_wr_en(r1_wr_en), .r1_addr(r1_addr), .r1_wr_data(r1_wr_data),
    .r1_gnt(r1_gnt), .r1_rd_valid(r1_rd_valid), .r1_rd_data(r1_rd_data),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_q)
`ifdef MEMREF_ARB_PERF_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Single-port memref: write at the edge, read data registered for the next cycle.
  logic [31:0] mem [64];
  logic loaded = 0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i == 32) ? 32'd0 : 32'(i + 1);
      loaded <= 1;
    end else if (mem_en) begin
      if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
      else mem_rd_q <= mem[mem_addr];
    end
  end

  typedef struct { int id; logic [31:0] data; int due; } rsp_t;
  rsp_t q[$];
  logic [31:0] ref_mem [64];
  int last = 1;
  int cyc = 0, nchk = 0, nfail = 0, gc0 = 0, gc1 = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", n, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (rst) begin
      while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
      chk("rst_rd_valid", {r0_rd_valid, r1_rd_valid}, 0);
      chk("rst_rd_data", {r0_rd_data, r1_rd_data}, 0);
    end else if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rd_valid", {r0_rd_valid, r1_rd_valid}, (e.id == 0) ? 2'b10 : 2'b01);
      chk("rd_data", (e.id == 0) ? r0_rd_data : r1_rd_data, e.data);
      chk("rd_other_data", (e.id == 0) ? r1_rd_data : r0_rd_data, 0);
    end else begin
      chk("idle_rd_valid", {r0_rd_valid, r1_rd_valid}, 0);
    end
  end

  task automatic step(input logic r, input logic e0, input logic w0, input logic [5:0] a0,
                      input logic [31:0] d0, input logic e1, input logic w1, input logic [5:0] a1,
                      input logic [31:0] d1, output logic g0, output logic g1);
    @(posedge clk);
    cyc++;
    #1;
`ifdef MEMREF_ARB_PERF_EN
    chk("conflict_cnt", conflict_cnt, exp_cnt);
`endif
    rst = r; r0_en = e0; r0_wr_en = w0; r0_addr = a0; r0_wr_data = d0;
    r1_en = e1; r1_wr_en = w1; r1_addr = a1; r1_wr_data = d1;
    #1;
    // Round robin: on a tie the requester that was not granted most recently wins.
    g0 = !r && e0 && (!e1 || last == 1);
    g1 = !r && e1 && (!e0 || last == 0);
    chk("gnt", {r0_gnt, r1_gnt}, {g0, g1});
    chk("mem_en", mem_en, g0 || g1);
    chk("mem_wr_en", mem_wr_en, g0 ? w0 : g1 ? w1 : 1'b0);
    chk("mem_addr", mem_addr, g0 ? a0 : g1 ? a1 : 6'd0);
    chk("mem_wr_data", mem_wr_data, g0 ? d0 : g1 ? d1 : 32'd0);
    gc0 += int'(r0_gnt);
    gc1 += int'(r1_gnt);
    if (g0 || g1) begin
      if (g0 ? w0 : w1) ref_mem[g0 ? a0 : a1] = g0 ? d0 : d1;
      else q.push_back('{g0 ? 0 : 1, ref_mem[g0 ? a0 : a1], cyc + 1});
      last = g0 ? 0 : 1;
    end
    if (r) last = 1;
`ifdef MEMREF_ARB_PERF_EN
    if (r) exp_cnt = 0;
    else if (e0 && e1 && exp_cnt < 65535) exp_cnt++;
`endif
  endtask

  initial begin
    logic g0, g1;
    logic he0, hw0, he1, hw1;
    logic [5:0] ha0, ha1;
    logic [31:0] hd0, hd1;
    for (int i = 0; i < 64; i++) ref_mem[i] = (i == 32) ? 32'd0 : 32'(i + 1);
    repeat (3) step(1, 1, 0, 0, 0, 1, 0, 0, 0, g0, g1);
    step(0, 1, 0, 7, 0, 1, 0, 8, 0, g0, g1);
    chk("first_contended_r0", {r0_gnt, r1_gnt}, 2'b10);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    step(0, 1, 0, 5, 0, 0, 0, 0, 0, g0, g1);
    step(0, 0, 0, 0, 0, 1, 0, 32, 0, g0, g1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    step(0, 1, 0, 1, 0, 1, 1, 1, 99, g0, g1);
    step(0, 0, 0, 0, 0, 1, 1, 1, 99, g0, g1);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, g0, g1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    gc0 = 0; gc1 = 0;
    for (int i = 0; i < 8; i++) step(0, 1, 0, 6'(i), 0, 1, 1, 6'(i + 40), 32'(i), g0, g1);
    chk("sustained_r0_cnt", gc0, 4);
    chk("sustained_r1_cnt", gc1, 4);
    step(0, 0, 0, 0, 0, 1, 0, 3, 0, g0, g1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    step(0, 1, 0, 2, 0, 1, 0, 4, 0, g0, g1);
    chk("prio_after_reset", {r0_gnt, r1_gnt}, 2'b10);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    he0 = 0; he1 = 0; hw0 = 0; hw1 = 0; ha0 = 0; ha1 = 0; hd0 = 0; hd1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!he0 && $urandom_range(0, 2) != 0) begin
        he0 = 1; hw0 = 1'($urandom); ha0 = 6'($urandom_range(0, 7)); hd0 = $urandom;
      end
      if (!he1 && $urandom_range(0, 2) != 0) begin
        he1 = 1; hw1 = 1'($urandom); ha1 = 6'($urandom_range(0, 7)); hd1 = $urandom;
      end
      step(($urandom_range(0, 60) == 0), he0, hw0, ha0, hd0, he1, hw1, ha1, hd1, g0, g1);
      if (g0) he0 = 0;
      if (g1) he1 = 0;
    end
`ifdef MEMREF_ARB_PERF_EN
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    for (int i = 0; i < 70000; i++) step(0, 1, 1, 6'(i), 32'(i), 1, 0, 6'(i + 1), 0, g0, g1);
    repeat (3) step(0, 1, 0, 9, 0, 1, 0, 10, 0, g0, g1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    chk("cnt_saturated", conflict_cnt, 16'hFFFF);
`endif
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end
endmodule
